prbs_checker: RTL and testbench

//  Serial receive-side checker for the 6-bit PRBS stream (P(x)=x^6+x^5+1, NOR zero-state extension).

---
 rtl/prbs_checker.sv | 124 ++++++++++++
 tb/tb_prbs_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Serial PRBS-6 (x^6+x^5+1) receive checker: self-syncs, locks,
// then flywheels on its own prediction and counts bit errors.
module prbs_checker #(
  parameter int NOR_EXT    = 1,
  parameter int LOCK_CNT   = 12,
  parameter int WIN        = 16,
  parameter int UNLOCK_ERR = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear_errs,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN + 1);
  localparam int EW = $clog2(UNLOCK_ERR + 1);

  logic [0:0]    state;
  logic [5:0]    hist;
  logic [2:0]    fill;
  logic [MW-1:0] match;
  logic [WW-1:0] win;
  logic [EW-1:0] win_err;

  logic          pred;
  logic          mism;
  logic [EW-1:0] win_err_nx;
  logic [MW-1:0] match_nx;
  logic          unlock;
  logic          win_end;
  logic          lock_hit;
  logic          cnt_sat;

  always_comb begin
    pred = hist[4] ^ hist[5];
    if (NOR_EXT != 0 && hist == 6'd0)
      pred = 1'b1;
  end

  assign mism       = bit_in ^ pred;
  assign win_err_nx = win_err + EW'(mism);
  assign match_nx   = match + MW'(1);
  assign unlock     = mism
                   && (win_err_nx == EW'(UNLOCK_ERR));
  assign win_end    = (win == WW'(WIN - 1));
  assign lock_hit   = !mism
                   && (match_nx == MW'(LOCK_CNT));
  assign cnt_sat    = &err_count;
  assign locked     = (state == LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SEARCH;
      hist    <= '0;
      fill    <= '0;
      match   <= '0;
      win     <= '0;
      win_err <= '0;
    end else if (bit_valid) begin
      unique case (state)
        SEARCH: begin
          hist <= {hist[4:0], bit_in};
          if (fill != 3'd6) begin
            fill <= fill + 3'd1;
          end else if (mism) begin
            match <= '0;
          end else if (lock_hit) begin
            state   <= LOCKED;
            match   <= '0;
            win     <= '0;
            win_err <= '0;
          end else begin
            match <= match_nx;
          end
        end
        LOCKED: begin
          // flywheel: feed back the prediction, not the line bit
          hist <= {hist[4:0], pred};
          if (unlock) begin
            state   <= SEARCH;
            fill    <= '0;
            match   <= '0;
            win     <= '0;
            win_err <= '0;
          end else if (win_end) begin
            win     <= '0;
            win_err <= '0;
          end else begin
            win     <= win + WW'(1);
            win_err <= win_err_nx;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= bit_valid && locked && mism;
      unique case (1'b1)
        clear_errs:
          err_count <= '0;
        (bit_valid && locked && mism && !cnt_sat):
          err_count <= err_count + ERR_W'(1);
        default:
          err_count <= err_count;
      endcase
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, flywheel errors,
// windowed unlock, idle cycles, all-zero input, saturation.
module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_valid;
  logic       bit_in;
  logic       clear_errs;
  logic       locked;
  logic       err_pulse;
  logic [3:0] err_count;

  prbs_checker #(.ERR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .clear_errs (clear_errs),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int npulse = 0;
  int idle_pulse = 0;
  logic [5:0] g;

  task automatic chk(input string tag,
                     input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
  endtask

  task automatic step(input logic b, input logic v);
    @(negedge clk);
    bit_in    = b;
    bit_valid = v;
    @(posedge clk);
    #1;
    if (err_pulse) npulse++;
    if (err_pulse && !v) idle_pulse++;
  endtask

  // reference generator, same polynomial and NOR extension
  task automatic send(input logic inv);
    logic b;
    b = (g[4] ^ g[5]) | (g == 6'd0);
    g = {g[4:0], b};
    step(b ^ inv, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    clear_errs = 1'b0;
    g          = 6'b000001;
    npulse     = 0;
    idle_pulse = 0;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int nv;
    int cyc;
    reset      = 1'b1;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    clear_errs = 1'b0;
    g          = 6'b000001;
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_count", err_count, 0);

    // 1: ideal stream
    do_reset();
    repeat (17) send(1'b0);
    chk("t1_prelock", locked, 0);
    send(1'b0);
    chk("t1_lock18", locked, 1);
    repeat (500) send(1'b0);
    chk("t1_count", err_count, 0);
    chk("t1_locked", locked, 1);
    chk("t1_pulses", npulse, 0);

    // 2: single inverted bit #100
    do_reset();
    repeat (99) send(1'b0);
    npulse = 0;
    send(1'b1);
    chk("t2_pulse", err_pulse, 1);
    send(1'b0);
    chk("t2_pulse_off", err_pulse, 0);
    repeat (50) send(1'b0);
    chk("t2_npulse", npulse, 1);
    chk("t2_count", err_count, 1);
    chk("t2_locked", locked, 1);

    // 2b: 3 errors at end of window 1, 3 at start of window 2
    do_reset();
    repeat (31) send(1'b0);
    repeat (6) send(1'b1);
    chk("t2b_locked", locked, 1);
    chk("t2b_count", err_count, 6);
    repeat (20) send(1'b0);
    chk("t2b_still", locked, 1);

    // 3: 4 errors in bits 37..45 (one window) -> unlock
    do_reset();
    repeat (36) send(1'b0);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    repeat (2) send(1'b0);
    send(1'b1);
    repeat (2) send(1'b0);
    chk("t3_3err_lock", locked, 1);
    send(1'b1);
    chk("t3_unlock", locked, 0);
    chk("t3_count", err_count, 4);
    repeat (17) send(1'b0);
    chk("t3_prerelock", locked, 0);
    send(1'b0);
    chk("t3_relock", locked, 1);
    chk("t3_count_hold", err_count, 4);

    // 4: bit_valid randomly low
    do_reset();
    nv  = 0;
    cyc = 0;
    while (nv < 40 && cyc < 1000) begin
      cyc++;
      if ($urandom_range(1, 0) == 1) begin
        nv++;
        send(nv == 30);
        if (nv == 17) chk("t4_prelock", locked, 0);
        if (nv == 18) chk("t4_lock18", locked, 1);
        if (nv == 30) chk("t4_pulse", err_pulse, 1);
      end else begin
        step(1'($urandom_range(1, 0)), 1'b0);
      end
    end
    chk("t4_budget", nv, 40);
    chk("t4_idle_pulse", idle_pulse, 0);
    chk("t4_count", err_count, 1);
    chk("t4_locked", locked, 1);

    // 5: all-zero input never locks
    do_reset();
    repeat (200) step(1'b0, 1'b1);
    chk("t5_zero_lock", locked, 0);
    chk("t5_zero_count", err_count, 0);
    chk("t5_zero_pulse", npulse, 0);
    g = 6'b000001;
    repeat (17) send(1'b0);
    chk("t5_prelock", locked, 0);
    send(1'b0);
    chk("t5_lock18", locked, 1);

    // 6: saturation, clear priority, async reset
    do_reset();
    repeat (18) send(1'b0);
    chk("t6_lock", locked, 1);
    for (int w = 0; w < 5; w++) begin
      repeat (3) send(1'b1);
      repeat (13) send(1'b0);
    end
    chk("t6_count15", err_count, 15);
    chk("t6_locked", locked, 1);
    send(1'b1);
    chk("t6_sat", err_count, 15);
    chk("t6_sat_pulse", err_pulse, 1);
    clear_errs = 1'b1;
    send(1'b1);
    clear_errs = 1'b0;
    chk("t6_clear", err_count, 0);
    chk("t6_clr_pulse", err_pulse, 1);
    chk("t6_clr_lock", locked, 1);
    send(1'b1);
    chk("t6_pre_rst_cnt", err_count, 1);
    chk("t6_pre_rst_lock", locked, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_arst_lock", locked, 0);
    chk("t6_arst_pulse", err_pulse, 0);
    chk("t6_arst_count", err_count, 0);
    #2;
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
